// File: rtl/axi4l_read_pipe.sv
// AXI4-Lite read slave front end: credit-limited AR acceptance, fixed-latency memory
// read with a tag pipeline, and an in-order first-word-fall-through response FIFO.
module axi4l_read_pipe #(
    parameter int unsigned MAX_OR     = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned MEM_DEPTH  = 2 ** ADDR_WIDTH
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       arvalid,
    output logic                       arready,
    input  logic [ADDR_WIDTH-1:0]      araddr,
    input  logic [1:0]                 arprot,
    output logic                       rvalid,
    input  logic                       rready,
    output logic [DATA_WIDTH-1:0]      rdata,
    output logic [1:0]                 rresp,
    output logic                       rden,
    output logic [ADDR_WIDTH-1:0]      rdaddr,
    input  logic [DATA_WIDTH-1:0]      rddata,
    input  logic [1:0]                 rdcollision,
    output logic [$clog2(MAX_OR):0]    outstanding
);

    localparam int unsigned PW = $clog2(MAX_OR);
    localparam int unsigned CW = PW + 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [1:0]            resp;
        logic [DATA_WIDTH-1:0] data;
    } rsp_t;

    logic                  unused_arprot;
    logic [CW-1:0]         cnt_q;
    logic                  ar_hs;
    logic                  r_hs;
    logic                  mapped;
    logic                  rden_q;
    logic [ADDR_WIDTH-1:0] rdaddr_q;
    logic [RD_LATENCY:0]   vld_q;
    logic [RD_LATENCY:0]   unm_q;
    logic                  fifo_wr;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [CW-1:0]         wr_ptr_q;
    logic [CW-1:0]         rd_ptr_q;
    rsp_t                  wr_rsp;
    rsp_t                  head;
    rsp_t                  mem_q [MAX_OR];

    assign unused_arprot = ^arprot;

    // Credit check straight off the registered counter; held low while in reset.
    assign arready = aresetn && (cnt_q != CW'(MAX_OR));
    assign ar_hs   = arvalid && arready;
    assign r_hs    = rvalid && rready;
    assign mapped  = ({1'b0, araddr} < (ADDR_WIDTH + 1)'(MEM_DEPTH));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q <= '0;
        end else if (ar_hs && !r_hs) begin
            cnt_q <= cnt_q + CW'(1);
        end else if (!ar_hs && r_hs) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign outstanding = cnt_q;

    // Memory request issue and {valid, unmapped} tag pipeline aligned to read data.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rden_q   <= 1'b0;
            rdaddr_q <= '0;
            vld_q    <= '0;
            unm_q    <= '0;
        end else begin
            rden_q <= ar_hs && mapped;
            if (ar_hs && mapped) begin
                rdaddr_q <= araddr;
            end
            vld_q <= {vld_q[RD_LATENCY-1:0], ar_hs};
            unm_q <= {unm_q[RD_LATENCY-1:0], ar_hs && !mapped};
        end
    end

    assign rden    = rden_q;
    assign rdaddr  = rdaddr_q;
    assign fifo_wr = vld_q[RD_LATENCY];

    always_comb begin
        wr_rsp = '0;
        if (unm_q[RD_LATENCY]) begin
            wr_rsp.resp = RESP_DECERR;
        end else begin
            wr_rsp.data = rddata;
            wr_rsp.resp = (rdcollision != 2'b00) ? RESP_SLVERR : RESP_OKAY;
        end
    end

    // Response FIFO; the extra pointer MSB separates full from empty.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr_q <= wr_ptr_q + CW'(1);
            end
            if (r_hs) begin
                rd_ptr_q <= rd_ptr_q + CW'(1);
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (fifo_wr) begin
            mem_q[wr_ptr_q[PW-1:0]] <= wr_rsp;
        end
    end

    assign head   = mem_q[rd_ptr_q[PW-1:0]];
    assign rvalid = !fifo_empty;
    assign rdata  = rvalid ? head.data : '0;
    assign rresp  = rvalid ? head.resp : 2'b00;

    // The credit counter must make this unreachable.
    ap_no_overflow: assert property (@(posedge aclk) disable iff (!aresetn)
                                     !(fifo_wr && fifo_full))
        else $error("response FIFO written while full");

endmodule

// File: tb/tb_axi4l_read_pipe.sv
// Randomized bench for axi4l_read_pipe: directed boundary cases plus a random
// mapped/unmapped stream, scored against an in-order transaction queue model.
module tb_axi4l_read_pipe;

    localparam int unsigned MAX_OR = 8;
    localparam int unsigned AW     = 8;
    localparam int unsigned DW     = 32;
    localparam int unsigned RL     = 3;
    localparam int unsigned MD     = 16;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          arvalid;
    logic          arready;
    logic [AW-1:0] araddr;
    logic [1:0]    arprot;
    logic          rvalid;
    logic          rready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rden;
    logic [AW-1:0] rdaddr;
    logic [DW-1:0] rddata;
    logic [1:0]    rdcollision;
    logic [$clog2(MAX_OR):0] outstanding;

    axi4l_read_pipe #(
        .MAX_OR(MAX_OR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .RD_LATENCY(RL), .MEM_DEPTH(MD)
    ) u_dut (
        .aclk(aclk), .aresetn(aresetn),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .rden(rden), .rdaddr(rdaddr), .rddata(rddata), .rdcollision(rdcollision),
        .outstanding(outstanding)
    );

    always #5 aclk = ~aclk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    always @(posedge aclk) cyc <= cyc + 1;

    // Memory model: word and collision flags per address, returned RL cycles after rden.
    logic [DW-1:0] mem_w  [256];
    logic [1:0]    coll_w [256];

    typedef struct packed {
        logic [DW-1:0] d;
        logic [1:0]    c;
    } rd_t;

    rd_t dl [RL];
    rd_t dl_in;

    always @(posedge aclk) begin
        if (rden) dl_in = {mem_w[rdaddr], coll_w[rdaddr]};
        else      dl_in = {DW'($urandom), 2'($urandom)};
        dl[0] <= dl_in;
        for (int i = 1; i < int'(RL); i++) dl[i] <= dl[i-1];
    end

    assign rddata      = dl[RL-1].d;
    assign rdcollision = dl[RL-1].c;

    typedef struct {
        logic [1:0]    resp;
        logic [DW-1:0] data;
        int            t;
    } exp_t;

    exp_t          exp_q [$];
    logic          exp_rden   = 1'b0;
    logic [AW-1:0] exp_rdaddr = '0;

    function automatic exp_t model(input logic [AW-1:0] a, input int t);
        exp_t r;
        r.t = t;
        if (a >= AW'(MD)) begin
            r.resp = 2'b11;
            r.data = '0;
        end else begin
            r.data = mem_w[a];
            r.resp = (coll_w[a] != 2'b00) ? 2'b10 : 2'b00;
        end
        return r;
    endfunction

    // Scoreboard: every cycle compares credit, rden, rvalid timing and head contents.
    always @(negedge aclk) begin
        logic hs_ar;
        logic exp_rv;
        if (!aresetn) begin
            exp_q.delete();
            exp_rden = 1'b0;
            check("rst_rvalid", rvalid, 1'b0);
            check("rst_outstanding", outstanding, 0);
        end else begin
            check("rden", rden, exp_rden);
            if (exp_rden) check("rdaddr", rdaddr, exp_rdaddr);
            check("outstanding", outstanding, exp_q.size());
            check("arready", arready, exp_q.size() != int'(MAX_OR));
            exp_rv = (exp_q.size() > 0) && (cyc >= exp_q[0].t + int'(RL) + 2);
            check("rvalid", rvalid, exp_rv);
            if (rvalid && exp_rv) begin
                check("rresp", rresp, exp_q[0].resp);
                check("rdata", rdata, exp_q[0].data);
            end
            if (exp_rv && rready) void'(exp_q.pop_front());
            hs_ar      = arvalid && (exp_q.size() + (exp_rv && rready) != int'(MAX_OR));
            hs_ar      = arvalid && ((exp_q.size() + ((exp_rv && rready) ? 1 : 0)) != int'(MAX_OR));
            exp_rden   = hs_ar && (araddr < AW'(MD));
            exp_rdaddr = araddr;
            if (hs_ar) exp_q.push_back(model(araddr, cyc));
        end
    end

    task automatic single_read(input logic [AW-1:0] a, input logic [1:0] e_resp,
                               input logic [DW-1:0] e_data);
        int lat;
        rready  = 1'b1;
        arvalid = 1'b1;
        araddr  = a;
        tick();
        arvalid = 1'b0;
        check("single_rden", rden, a < AW'(MD));
        if (a < AW'(MD)) check("single_rdaddr", rdaddr, a);
        lat = 1;
        while (!rvalid && lat < 20) begin
            tick();
            lat++;
        end
        check("single_latency", lat, RL + 2);
        check("single_rresp", rresp, e_resp);
        check("single_rdata", rdata, e_data);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int rprob;
        for (int i = 0; i < 256; i++) begin
            mem_w[i]  = $urandom;
            coll_w[i] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        end
        mem_w[5]  = 32'hCAFE_F00D;
        coll_w[5] = 2'b00;
        mem_w[7]  = 32'h1234_5678;
        coll_w[7] = 2'b01;

        aresetn = 1'b0;
        arvalid = 1'b0;
        araddr  = '0;
        arprot  = '0;
        rready  = 1'b0;
        repeat (3) tick();
        check("rst_arready", arready, 1'b0);
        check("rst_rden", rden, 1'b0);
        check("rst_rdaddr", rdaddr, 0);
        check("rst_rdata", rdata, 0);
        check("rst_rresp", rresp, 0);
        aresetn = 1'b1;
        #1;
        check("arready_after_rst", arready, 1'b1);
        tick();

        single_read(8'h05, 2'b00, 32'hCAFE_F00D);
        single_read(8'h20, 2'b11, 32'h0);
        single_read(8'h07, 2'b10, 32'h1234_5678);

        // Fill all credits with rready low, then release exactly one response.
        rready = 1'b0;
        for (int i = 0; i < int'(MAX_OR); i++) begin
            arvalid = 1'b1;
            araddr  = AW'(i * 3);
            tick();
        end
        arvalid = 1'b0;
        check("full_arready", arready, 1'b0);
        check("full_outstanding", outstanding, MAX_OR);
        rready = 1'b1;
        #1;
        check("full_arready_same_cycle", arready, 1'b0);
        tick();
        rready = 1'b0;
        check("full_arready_next", arready, 1'b1);
        check("full_outstanding_next", outstanding, MAX_OR - 1);
        rready = 1'b1;
        repeat (12) tick();
        check("full_drained", outstanding, 0);

        // Random mixed stream with varying back-pressure.
        for (int p = 0; p < 4; p++) begin
            rprob = (p == 0) ? 20 : (p == 1) ? 50 : (p == 2) ? 90 : 100;
            repeat (200) begin
                arvalid = ($urandom_range(0, 2) != 0);
                araddr  = AW'($urandom_range(0, 31));
                arprot  = 2'($urandom);
                rready  = ($urandom_range(0, 99) < rprob);
                tick();
            end
        end
        arvalid = 1'b0;
        rready  = 1'b1;
        n = 0;
        while ((outstanding != 0 || rvalid) && n < 100) begin
            tick();
            n++;
        end
        check("random_drain_outstanding", outstanding, 0);
        check("random_drain_rvalid", rvalid, 1'b0);

        // Reset with requests both queued and still in the tag pipeline.
        rready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            arvalid = 1'b1;
            araddr  = (i == 2) ? 8'h20 : AW'(i + 1);
            tick();
        end
        arvalid = 1'b0;
        repeat (2) tick();
        aresetn = 1'b0;
        #1;
        check("midrst_arready", arready, 1'b0);
        check("midrst_rvalid", rvalid, 1'b0);
        check("midrst_rden", rden, 1'b0);
        check("midrst_rdaddr", rdaddr, 0);
        check("midrst_rdata", rdata, 0);
        check("midrst_rresp", rresp, 0);
        check("midrst_outstanding", outstanding, 0);
        repeat (2) tick();
        aresetn = 1'b1;
        rready  = 1'b1;
        n = 0;
        repeat (15) begin
            if (rvalid) n++;
            tick();
        end
        check("midrst_no_stale", n, 0);
        single_read(8'h05, 2'b00, 32'hCAFE_F00D);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/axi4l_read_pipe.md
AXI4L_READ_PIPE -- requirements
Module: axi4l_read_pipe

Interface
REQ-001 SHALL have parameter MAX_OR, default 8, max outstanding reads; power of two, >= 2.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, address width in bits.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, data width in bits.
REQ-004 SHALL have parameter RD_LATENCY, default 1, memory read latency in cycles; legal range 1..4.
REQ-005 SHALL have parameter MEM_DEPTH, default 2**ADDR_WIDTH, number of decoded words; addresses >= MEM_DEPTH are unmapped.
REQ-006 SHALL use one clock and an asynchronous active-low reset, with ports named aclk and aresetn.
REQ-007 aclk  input  1  single clock, rising edge.
REQ-008 aresetn  input  1  asynchronous active-low reset.
REQ-009 arvalid  input  1  read address valid.
REQ-010 arready  output  1  read address ready.
REQ-011 araddr  input  ADDR_WIDTH  read word address.
REQ-012 arprot  input  2  protection; ignored.
REQ-013 rvalid  output  1  read data valid.
REQ-014 rready  input  1  read data ready.
REQ-015 rdata  output  DATA_WIDTH  read data.
REQ-016 rresp  output  2  read response.
REQ-017 rden  output  1  memory read enable, one-cycle pulse per mapped request.
REQ-018 rdaddr  output  ADDR_WIDTH  memory read address, valid when rden=1.
REQ-019 rddata  input  DATA_WIDTH  memory read data.
REQ-020 rdcollision  input  2  memory collision flags, sampled with rddata.
REQ-021 outstanding  output  $clog2(MAX_OR)+1  accepted-but-uncompleted read count.

Function
REQ-022 AR handshake SHALL occur when arvalid=1 and arready=1 on a rising edge.
REQ-023 arready SHALL equal (outstanding != MAX_OR), combinationally from the registered counter, independent of arvalid.
REQ-024 outstanding SHALL increment on AR handshake only, decrement on R handshake only, and hold when both or neither occur.
REQ-025 For an AR handshake in cycle T with araddr < MEM_DEPTH, rden SHALL be 1 and rdaddr = captured araddr in cycle T+1 (registered).
REQ-026 For araddr >= MEM_DEPTH, rden SHALL stay 0; the request SHALL still enter the pipeline, tagged unmapped.
REQ-027 A tag pipeline of RD_LATENCY stages SHALL carry {valid, unmapped} from cycle T+1 to cycle T+1+RD_LATENCY.
REQ-028 In cycle T+1+RD_LATENCY the block SHALL write {rresp, rdata} into a synchronous response FIFO of depth MAX_OR at the closing edge.
REQ-029 Response encoding: unmapped -> rresp=2'b11 (DECERR), rdata=0; mapped and rdcollision!=0 -> 2'b10 (SLVERR), rdata=rddata; else 2'b00 (OKAY), rdata=rddata.
REQ-030 rvalid SHALL equal FIFO not-empty; rdata/rresp SHALL present the FIFO head (first-word fall-through); head pops on R handshake.
REQ-031 Minimum AR-to-rvalid latency SHALL be RD_LATENCY+2 cycles (rvalid first high in cycle T+2+RD_LATENCY).
REQ-032 Responses SHALL return in AR acceptance order, mapped and unmapped interleaved.
REQ-033 Back-to-back ARs SHALL be accepted at one per cycle while outstanding < MAX_OR.
REQ-034 The credit rule (REQ-023) SHALL guarantee no FIFO overflow; a FIFO write while full is a design error, flagged by a simulation assertion.
REQ-035 Full boundary: with outstanding=MAX_OR, an R handshake in cycle C SHALL make arready=1 in cycle C+1, not C.
REQ-036 rvalid/rdata/rresp SHALL stay stable while rvalid=1 and rready=0.
REQ-037 FIFO pointers SHALL wrap modulo MAX_OR using an extra MSB to distinguish full from empty.

Reset
REQ-038 When aresetn=0: arready=0, rvalid=0, rden=0, rdaddr=0, rdata=0, rresp=0, outstanding=0, tag pipeline cleared, FIFO empty.
REQ-039 arready SHALL rise in the first cycle after aresetn deasserts.
REQ-040 Reset mid-operation SHALL discard all in-flight and queued requests; no response for them SHALL appear after reset.

Verification
REQ-041 Single read, RD_LATENCY=1, araddr=0x05, rddata=0xCAFEF00D, rdcollision=0: AR at T -> rden at T+1 with rdaddr=0x05; rvalid at T+3 with rdata=0xCAFEF00D, rresp=00.
REQ-042 MEM_DEPTH=16, araddr=0x20 -> rden never 1; rvalid after RD_LATENCY+2 cycles with rdata=0, rresp=11.
REQ-043 rready=0, 8 back-to-back ARs (MAX_OR=8) -> arready=0 after 8th handshake, outstanding=8; one R handshake -> arready=1 next cycle, outstanding=7.
REQ-044 rdcollision=2'b01 on a mapped read -> rresp=10, rdata=rddata.
REQ-045 Mixed mapped/unmapped stream, random rready, RD_LATENCY=3 -> responses in order, none lost or duplicated, no FIFO overflow assertion.
REQ-046 aresetn pulsed low with 4 requests in flight -> all outputs per REQ-038; no stale rvalid after release.
